// File: rtl/conbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conbus_pkg
// Purpose  : Shared conbus definitions (state encoding, slave decode field).
// Revision : 1.0
// ============================================================================
package conbus_pkg;

    localparam int CONBUS_NSLAVES = 8;

    // Slave index field; the master-side mux decodes the same bits
    localparam int CONBUS_IDX_MSB = 31;
    localparam int CONBUS_IDX_LSB = 29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } conbus_state_t;

endpackage
`default_nettype wire

// File: rtl/conbus_slvsel.sv
`default_nettype none
// ============================================================================
// Module   : conbus_slvsel
// Purpose  : Steers the forwarded master cycle to one of eight slaves and
//            terminates unmapped, timed-out or abandoned cycles.
// Revision : 1.0
// ============================================================================
module conbus_slvsel
    import conbus_pkg::*;
#(
    parameter logic [CONBUS_NSLAVES-1:0] SLAVE_MASK = 8'b0111_1111,
    parameter int                        TIMEOUT    = 1023,
    parameter int                        TW         = 10
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [31:0]               m_adr,
    input  logic                      m_cyc,
    input  logic                      m_stb,
    output logic                      m_ack,
    output logic                      m_err,
    output logic [CONBUS_NSLAVES-1:0] s_stb,
    input  logic [CONBUS_NSLAVES-1:0] s_ack,
    output logic [31:0]               err_adr,
    output logic                      err_timeout
);

    localparam logic [TW-1:0] c_cnt_last = TW'(TIMEOUT - 1);

    conbus_state_t               r_state;
    logic [CONBUS_NSLAVES-1:0]   r_sel;
    logic [TW-1:0]               r_cnt;
    logic [31:0]                 r_err_adr;
    logic                        r_err_timeout;

    logic [CONBUS_IDX_MSB-CONBUS_IDX_LSB:0] w_idx;
    logic                                   w_req;
    logic                                   w_active;
    logic                                   w_ack;

    assign w_idx    = m_adr[CONBUS_IDX_MSB:CONBUS_IDX_LSB];
    assign w_req    = m_cyc & m_stb;
    assign w_active = (r_state == ST_ACTIVE);
    assign w_ack    = w_active & (|(s_ack & r_sel));

    assign s_stb       = w_active ? (r_sel & {CONBUS_NSLAVES{w_req}}) : '0;
    assign m_ack       = w_ack;
    assign m_err       = (r_state == ST_ERR);
    assign err_adr     = r_err_adr;
    assign err_timeout = r_err_timeout;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_cnt         <= '0;
            r_err_adr     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (SLAVE_MASK[w_idx]) begin
                            r_state <= ST_ACTIVE;
                            r_sel   <= CONBUS_NSLAVES'(1) << w_idx;
                            r_cnt   <= '0;
                        end else begin
                            r_state       <= ST_ERR;
                            r_err_adr     <= m_adr;
                            r_err_timeout <= 1'b0;
                        end
                    end
                end
                // Ack beats abort beats timeout within the same cycle
                ST_ACTIVE: begin
                    if (w_ack) begin
                        r_state <= ST_IDLE;
                        r_sel   <= '0;
                    end else if (!m_cyc) begin
                        r_state <= ST_IDLE;
                        r_sel   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state       <= ST_ERR;
                        r_sel         <= '0;
                        r_err_adr     <= m_adr;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
